// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: two-port round-robin write arbiter in front of a register file.
//
// Port 0 (ALU writeback) and port 1 (load / multi-cycle unit) each offer a
// valid/ready write request. One request is granted per cycle. The granted
// write reaches the register file one cycle later. Register 0 is hard-wired,
// so a write to wn=0 is accepted but never asserts rf_we.
//
// Ports:
//   clk                 clock, rising edge
//   clr                 asynchronous active-high clear
//   req0_valid/_ready   port 0 handshake; req0_wn, req0_d destination and data
//   req1_valid/_ready   port 1 handshake; req1_wn, req1_d destination and data
//   rf_we, rf_wn, rf_d  registered register-file write port
//   stall_cnt           saturating count of dual-request edges
//
// Optional feature: define REGARB_STALLCNT_EN to add the stall_cnt port and counter.
module regfile_wr_arb (
    input  logic        clk,
    input  logic        clr,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_wn,
    input  logic [31:0] req0_d,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_wn,
    input  logic [31:0] req1_d,
    output logic        rf_we,
    output logic [4:0]  rf_wn,
    output logic [31:0] rf_d
`ifdef REGARB_STALLCNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    // Port number granted most recently; resets to 1 so port 0 wins the first conflict.
    logic        last_q;
    logic        last_d;
    logic        grant0;
    logic        grant1;
    logic        xfer;
    logic [4:0]  wn_sel;
    logic [31:0] d_sel;
    logic        we_q;
    logic [4:0]  wn_q;
    logic [31:0] d_q;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!clr) begin
            if (req0_valid && req1_valid) begin
                // Conflict: favour the port not granted last time.
                grant0 = last_q;
                grant1 = ~last_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign xfer       = grant0 | grant1;
    assign wn_sel     = grant1 ? req1_wn : req0_wn;
    assign d_sel      = grant1 ? req1_d  : req0_d;
    assign last_d     = xfer ? grant1 : last_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            last_q <= 1'b1;
            we_q   <= 1'b0;
            wn_q   <= 5'd0;
            d_q    <= 32'd0;
        end else begin
            last_q <= last_d;
            we_q   <= xfer && (wn_sel != 5'd0);
            if (xfer) begin
                wn_q <= wn_sel;
                d_q  <= d_sel;
            end
        end
    end

    assign rf_we = we_q;
    assign rf_wn = wn_q;
    assign rf_d  = d_q;

`ifdef REGARB_STALLCNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (req0_valid && req1_valid && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_regfile_wr_arb.sv
module tb_regfile_wr_arb;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [4:0]  req0_wn = 5'd0;
    logic [31:0] req0_d = 32'd0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [4:0]  req1_wn = 5'd0;
    logic [31:0] req1_d = 32'd0;
    logic        rf_we;
    logic [4:0]  rf_wn;
    logic [31:0] rf_d;
`ifdef REGARB_STALLCNT_EN
    logic [15:0] stall_cnt;
`endif

    regfile_wr_arb dut (
        .clk        (clk),
        .clr        (clr),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_wn    (req0_wn),
        .req0_d     (req0_d),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_wn    (req1_wn),
        .req1_d     (req1_d),
        .rf_we      (rf_we),
        .rf_wn      (rf_wn),
        .rf_d       (rf_d)
`ifdef REGARB_STALLCNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: which port wins, from the arbitration rules.
    function automatic logic [1:0] exp_grant(input logic v0, input logic v1,
                                             input logic last, input logic rst);
        if (rst) return 2'b00;
        if (v0 && v1) return last ? 2'b01 : 2'b10;
        return {v1, v0};
    endfunction

    logic        m_last = 1'b1;
    logic        m_we   = 1'b0;
    logic [4:0]  m_wn   = 5'd0;
    logic [31:0] m_d    = 32'd0;
    int          m_stall = 0;
    logic [1:0]  m_took = 2'b00;
    logic [1:0]  m_g;

    assign m_g = exp_grant(req0_valid, req1_valid, m_last, clr);

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_last  <= 1'b1;
            m_we    <= 1'b0;
            m_wn    <= 5'd0;
            m_d     <= 32'd0;
            m_stall <= 0;
            m_took  <= 2'b00;
        end else begin
            m_took <= m_g;
            if (m_g != 2'b00) begin
                m_last <= m_g[1];
                m_wn   <= m_g[1] ? req1_wn : req0_wn;
                m_d    <= m_g[1] ? req1_d : req0_d;
                m_we   <= (m_g[1] ? req1_wn : req0_wn) != 5'd0;
            end else begin
                m_we <= 1'b0;
            end
            if (req0_valid && req1_valid && m_stall < 65535) m_stall <= m_stall + 1;
        end
    end

    // Compare process: away from the active edge, every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("req0_ready", {31'd0, req0_ready}, {31'd0, m_g[0]});
            check("req1_ready", {31'd0, req1_ready}, {31'd0, m_g[1]});
            check("rf_we", {31'd0, rf_we}, {31'd0, m_we});
            check("rf_wn", {27'd0, rf_wn}, {27'd0, m_wn});
            check("rf_d", rf_d, m_d);
`ifdef REGARB_STALLCNT_EN
            check("stall_cnt", {16'd0, stall_cnt}, m_stall);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        clr = 1'b1;
        step();
        step();
        clr = 1'b0;
    endtask

    logic [5:0] exp_seq;
    logic [5:0] got_seq;

    initial begin
        step();
        chk_en = 1'b1;
        // Reset state, with requests present: nothing granted, outputs cleared.
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #2;
        check("reset_ready0", {31'd0, req0_ready}, 32'd0);
        check("reset_ready1", {31'd0, req1_ready}, 32'd0);
        check("reset_rf_we", {31'd0, rf_we}, 32'd0);
        check("reset_rf_wn", {27'd0, rf_wn}, 32'd0);
        check("reset_rf_d", rf_d, 32'd0);
        do_reset();

        // Single write.
        req0_valid = 1'b1; req0_wn = 5'd5; req0_d = 32'hDEADBEEF;
        #2;
        check("single_ready0", {31'd0, req0_ready}, 32'd1);
        step();
        req0_valid = 1'b0;
        #1;
        check("single_we", {31'd0, rf_we}, 32'd1);
        check("single_wn", {27'd0, rf_wn}, 32'd5);
        check("single_d", rf_d, 32'hDEADBEEF);
        step();
        check("single_we_off", {31'd0, rf_we}, 32'd0);

        // First conflict after reset.
        do_reset();
        req0_valid = 1'b1; req0_wn = 5'd3; req0_d = 32'h33;
        req1_valid = 1'b1; req1_wn = 5'd4; req1_d = 32'h44;
        #2;
        check("conf1_ready0", {31'd0, req0_ready}, 32'd1);
        check("conf1_ready1", {31'd0, req1_ready}, 32'd0);
        step();
        req0_valid = 1'b0;
        #1;
        check("conf1_wn", {27'd0, rf_wn}, 32'd3);
        check("conf2_ready1", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        #1;
        check("conf2_wn", {27'd0, rf_wn}, 32'd4);

        // Starvation: six dual-request cycles alternate 0,1,0,1,0,1.
        do_reset();
        exp_seq = 6'b101010;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #2;
            got_seq[i] = req1_ready;
            step();
        end
        idle_inputs();
        check("starve_seq", {26'd0, got_seq}, {26'd0, exp_seq});
`ifdef REGARB_STALLCNT_EN
        check("starve_stall", {16'd0, stall_cnt}, 32'd6);
`endif

        // Write to x0 on port 1, then a conflict goes to port 0.
        req1_valid = 1'b1; req1_wn = 5'd0; req1_d = 32'h1;
        #2;
        check("x0_ready1", {31'd0, req1_ready}, 32'd1);
        step();
        req1_valid = 1'b0;
        #1;
        check("x0_we", {31'd0, rf_we}, 32'd0);
        check("x0_d", rf_d, 32'h1);
        req0_valid = 1'b1; req0_wn = 5'd9;
        req1_valid = 1'b1; req1_wn = 5'd10;
        #1;
        check("x0_next_ready0", {31'd0, req0_ready}, 32'd1);
        step();
        idle_inputs();

        // Clear arriving before the write is consumed.
        step();
        req0_valid = 1'b1; req0_wn = 5'd7; req0_d = 32'hAA;
        step();
        req0_valid = 1'b0;
        #1;
        check("midrst_we_before", {31'd0, rf_we}, 32'd1);
        clr = 1'b1;
        #1;
        check("midrst_we", {31'd0, rf_we}, 32'd0);
        check("midrst_wn", {27'd0, rf_wn}, 32'd0);
        check("midrst_d", rf_d, 32'd0);
        step();
        clr = 1'b0;
        step();
        check("midrst_idle_we", {31'd0, rf_we}, 32'd0);

        // Randomized traffic; a stalled request holds its payload.
        for (int i = 0; i < 2000; i++) begin
            if (clr) clr = 1'b0;
            if (!(req0_valid && !m_took[0])) begin
                req0_valid = ($urandom % 4) != 0;
                req0_wn    = ($urandom % 5 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                req0_d     = $urandom;
            end
            if (!(req1_valid && !m_took[1])) begin
                req1_valid = ($urandom % 3) != 0;
                req1_wn    = ($urandom % 5 == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                req1_d     = $urandom;
            end
            if ($urandom % 150 == 0) begin
                #2;
                clr = 1'b1;
            end
            step();
        end
        clr = 1'b0;
        idle_inputs();
        step();

`ifdef REGARB_STALLCNT_EN
        // Saturation of the stall counter.
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            req0_wn = 5'($urandom);
            req1_wn = 5'($urandom);
            step();
        end
        check("sat_stall", {16'd0, stall_cnt}, 32'h0000FFFF);
        step();
        step();
        check("sat_stall_hold", {16'd0, stall_cnt}, 32'h0000FFFF);
        idle_inputs();
        step();
`endif

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
